// File: rtl/rgmii_rx_adapter.sv
// RGMII receive adapter: DDR capture, rising-edge re-time, 10/100 nibble
// pairing or gigabit byte pass-through, plus in-band link status decode.
module rgmii_rx_adapter #(
  parameter int PIPE_STAGES   = 1,
  parameter bit INBAND_STATUS = 1'b1
) (
  input  logic       RGMII_RxClk,
  input  logic       rst,
  input  logic [3:0] RGMII_RxD,
  input  logic       RGMII_RxCtl,
  input  logic [1:0] Speed,
  output logic [7:0] RxD,
  output logic       RxDV,
  output logic       RxER,
  output logic       RxValid,
  output logic       DribbleErr,
  output logic       LinkUp,
  output logic [1:0] LinkSpeed,
  output logic       FullDuplex,
  output logic       StatusValid
);

  typedef struct packed {
    logic [7:0] d;
    logic       dv;
    logic       er;
    logic       vld;
    logic       drib;
  } rx_t;

  logic [3:0] rise_d_q;
  logic       rise_dv_q;
  logic       smp_q;
  logic [3:0] fall_d_q;
  logic       fall_c2_q;

  always_ff @(posedge RGMII_RxClk or posedge rst) begin
    if (rst) begin
      rise_d_q  <= '0;
      rise_dv_q <= 1'b0;
      smp_q     <= 1'b0;
    end else begin
      rise_d_q  <= RGMII_RxD;
      rise_dv_q <= RGMII_RxCtl;
      smp_q     <= 1'b1;
    end
  end

  always_ff @(negedge RGMII_RxClk or posedge rst) begin
    if (rst) begin
      fall_d_q  <= '0;
      fall_c2_q <= 1'b0;
    end else begin
      fall_d_q  <= RGMII_RxD;
      fall_c2_q <= RGMII_RxCtl;
    end
  end

  logic       dv_w;
  logic       er_w;
  logic       gig_w;

  logic       phase_q, phase_d;
  logic [3:0] pend_q, pend_d;
  logic       pend_er_q, pend_er_d;
  logic       prev_dv_q, prev_dv_d;
  logic       ok_q, ok_d;
  logic [1:0] spd_q, spd_d;
  logic [3:0] sprev_q, sprev_d;
  logic       sprev_vld_q, sprev_vld_d;
  logic       link_q, link_d;
  logic [1:0] lspd_q, lspd_d;
  logic       fdx_q, fdx_d;
  logic       sv_q, sv_d;
  rx_t        st_d;
  rx_t        pipe_q [0:PIPE_STAGES];

  assign dv_w  = rise_dv_q;
  assign er_w  = rise_dv_q ^ fall_c2_q;
  assign gig_w = spd_q[1];

  // smp_q marks capture registers holding post-reset data; ok_q marks
  // that an idle sample was seen, so a frame needs a real DV rise.
  always_comb begin
    st_d        = pipe_q[0];
    st_d.vld    = 1'b0;
    st_d.drib   = 1'b0;
    phase_d     = phase_q;
    pend_d      = pend_q;
    pend_er_d   = pend_er_q;
    prev_dv_d   = prev_dv_q;
    ok_d        = ok_q;
    spd_d       = spd_q;
    sprev_d     = sprev_q;
    sprev_vld_d = sprev_vld_q;
    link_d      = link_q;
    lspd_d      = lspd_q;
    fdx_d       = fdx_q;
    sv_d        = sv_q;
    if (smp_q) begin
      prev_dv_d = dv_w;
      if (!dv_w) begin
        ok_d  = 1'b1;
        spd_d = Speed;
      end
      if (gig_w) begin
        phase_d  = 1'b0;
        st_d.d   = {fall_d_q, rise_d_q};
        st_d.dv  = dv_w & ok_q;
        st_d.er  = er_w & (ok_q | ~dv_w);
        st_d.vld = 1'b1;
      end else if (dv_w) begin
        if (ok_q) begin
          if (!phase_q || !prev_dv_q) begin
            phase_d   = 1'b1;
            pend_d    = rise_d_q;
            pend_er_d = er_w;
          end else begin
            phase_d  = 1'b0;
            st_d.d   = {rise_d_q, pend_q};
            st_d.dv  = 1'b1;
            st_d.er  = er_w | pend_er_q;
            st_d.vld = 1'b1;
          end
        end
      end else begin
        st_d.drib = phase_q;
        phase_d   = 1'b0;
        if (er_w) begin
          st_d.d   = {rise_d_q, rise_d_q};
          st_d.dv  = 1'b0;
          st_d.er  = 1'b1;
          st_d.vld = 1'b1;
        end
      end
      if (INBAND_STATUS && !dv_w && !er_w) begin
        sprev_d     = rise_d_q;
        sprev_vld_d = 1'b1;
        if (sprev_vld_q && (sprev_q == rise_d_q)) begin
          link_d = rise_d_q[0];
          lspd_d = rise_d_q[2:1];
          fdx_d  = rise_d_q[3];
          sv_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge RGMII_RxClk or posedge rst) begin
    if (rst) begin
      phase_q     <= 1'b0;
      pend_q      <= '0;
      pend_er_q   <= 1'b0;
      prev_dv_q   <= 1'b0;
      ok_q        <= 1'b0;
      spd_q       <= '0;
      sprev_q     <= '0;
      sprev_vld_q <= 1'b0;
      link_q      <= 1'b0;
      lspd_q      <= '0;
      fdx_q       <= 1'b0;
      sv_q        <= 1'b0;
      for (int i = 0; i <= PIPE_STAGES; i++)
        pipe_q[i] <= '0;
    end else begin
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      pend_er_q   <= pend_er_d;
      prev_dv_q   <= prev_dv_d;
      ok_q        <= ok_d;
      spd_q       <= spd_d;
      sprev_q     <= sprev_d;
      sprev_vld_q <= sprev_vld_d;
      link_q      <= link_d;
      lspd_q      <= lspd_d;
      fdx_q       <= fdx_d;
      sv_q        <= sv_d;
      pipe_q[0]   <= st_d;
      for (int i = 1; i <= PIPE_STAGES; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign RxD         = pipe_q[PIPE_STAGES].d;
  assign RxDV        = pipe_q[PIPE_STAGES].dv;
  assign RxER        = pipe_q[PIPE_STAGES].er;
  assign RxValid     = pipe_q[PIPE_STAGES].vld;
  assign DribbleErr  = pipe_q[PIPE_STAGES].drib;
  assign LinkUp      = link_q;
  assign LinkSpeed   = lspd_q;
  assign FullDuplex  = fdx_q;
  assign StatusValid = sv_q;

endmodule

// File: tb/tb_rgmii_rx_adapter.sv
// Directed bench for rgmii_rx_adapter: one instance with a single
// output stage, one with none, sharing the same RGMII stimulus.
module tb_rgmii_rx_adapter;

  logic       clk;
  logic       rst;
  logic [3:0] rxd_in;
  logic       ctl_in;
  logic [1:0] speed;

  logic [7:0] a_d, b_d;
  logic       a_dv, a_er, a_vld, a_dr;
  logic       b_dv, b_er, b_vld, b_dr;
  logic       a_lu, a_fd, a_sv;
  logic       b_lu, b_fd, b_sv;
  logic [1:0] a_ls, b_ls;

  int n_chk = 0;
  int n_fail = 0;

  rgmii_rx_adapter #(.PIPE_STAGES(1), .INBAND_STATUS(1'b1)) u_a (
    .RGMII_RxClk(clk), .rst(rst), .RGMII_RxD(rxd_in),
    .RGMII_RxCtl(ctl_in), .Speed(speed),
    .RxD(a_d), .RxDV(a_dv), .RxER(a_er), .RxValid(a_vld),
    .DribbleErr(a_dr), .LinkUp(a_lu), .LinkSpeed(a_ls),
    .FullDuplex(a_fd), .StatusValid(a_sv)
  );

  rgmii_rx_adapter #(.PIPE_STAGES(0), .INBAND_STATUS(1'b1)) u_b (
    .RGMII_RxClk(clk), .rst(rst), .RGMII_RxD(rxd_in),
    .RGMII_RxCtl(ctl_in), .Speed(speed),
    .RxD(b_d), .RxDV(b_dv), .RxER(b_er), .RxValid(b_vld),
    .DribbleErr(b_dr), .LinkUp(b_lu), .LinkSpeed(b_ls),
    .FullDuplex(b_fd), .StatusValid(b_sv)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One RGMII cycle: L and rising ctl before the rising edge,
  // H and falling ctl before the falling edge.
  task automatic nib(input logic [3:0] l, input logic [3:0] h,
                     input logic dv, input logic c2);
    @(negedge clk);
    #2;
    rxd_in = l;
    ctl_in = dv;
    @(posedge clk);
    #2;
    rxd_in = h;
    ctl_in = c2;
  endtask

  function automatic logic [11:0] ex(input logic [7:0] d, input logic dv,
                                     input logic er, input logic vld,
                                     input logic dr);
    return {d, dv, er, vld, dr};
  endfunction

  function automatic logic [11:0] oa();
    return {a_d, a_dv, a_er, a_vld, a_dr};
  endfunction

  function automatic logic [11:0] ob();
    return {b_d, b_dv, b_er, b_vld, b_dr};
  endfunction

  function automatic logic [4:0] sa();
    return {a_lu, a_ls, a_fd, a_sv};
  endfunction

  initial begin
    rst    = 1'b1;
    speed  = 2'b10;
    rxd_in = 4'hD;
    ctl_in = 1'b0;
    repeat (2) nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("rst_a_out", 32'(oa()), 32'(ex(8'h00, 0, 0, 0, 0)));
    chk("rst_b_out", 32'(ob()), 32'(ex(8'h00, 0, 0, 0, 0)));
    chk("rst_status", 32'(sa()), 32'h0);
    rst = 1'b0;

    // idle 0xD: status after two qualifying samples, not one
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("stat_one_sample", 32'(a_sv), 32'h0);
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("stat_d", 32'(sa()), 32'(5'b1_10_1_1));
    chk("stat_d_b", 32'({b_lu, b_ls, b_fd, b_sv}), 32'(5'b1_10_1_1));
    nib(4'h0, 4'h0, 1'b0, 1'b0);
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("stat_glitch", 32'(sa()), 32'(5'b1_10_1_1));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("stat_glitch2", 32'(sa()), 32'(5'b1_10_1_1));

    // gigabit frame 55 D5 3A, then DV=1/ER=1, then false carrier
    nib(4'h5, 4'h5, 1'b1, 1'b1);
    nib(4'h5, 4'hD, 1'b1, 1'b1);
    chk("g_b_55", 32'(ob()), 32'(ex(8'h55, 1, 0, 1, 0)));
    nib(4'hA, 4'h3, 1'b1, 1'b1);
    chk("g_a_55", 32'(oa()), 32'(ex(8'h55, 1, 0, 1, 0)));
    chk("g_b_d5", 32'(ob()), 32'(ex(8'hD5, 1, 0, 1, 0)));
    speed = 2'b01;
    nib(4'h1, 4'h2, 1'b1, 1'b0);
    chk("g_a_d5", 32'(oa()), 32'(ex(8'hD5, 1, 0, 1, 0)));
    chk("g_b_3a_spd_hold", 32'(ob()), 32'(ex(8'h3A, 1, 0, 1, 0)));
    nib(4'hF, 4'hF, 1'b0, 1'b1);
    chk("g_a_3a", 32'(oa()), 32'(ex(8'h3A, 1, 0, 1, 0)));
    chk("g_b_dv_er", 32'(ob()), 32'(ex(8'h21, 1, 1, 1, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("g_a_dv_er", 32'(oa()), 32'(ex(8'h21, 1, 1, 1, 0)));
    chk("g_b_fcar", 32'(ob()), 32'(ex(8'hFF, 0, 1, 1, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("g_a_fcar", 32'(oa()), 32'(ex(8'hFF, 0, 1, 1, 0)));
    chk("m_b_idle", 32'(ob()), 32'(ex(8'hFF, 0, 1, 0, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);

    // 100M: nibbles 5 5 5 D
    nib(4'h5, 4'h5, 1'b1, 1'b1);
    nib(4'h5, 4'h5, 1'b1, 1'b1);
    chk("m_b_hold", 32'(ob()), 32'(ex(8'hFF, 0, 1, 0, 0)));
    nib(4'h5, 4'h5, 1'b1, 1'b1);
    chk("m_b_55", 32'(ob()), 32'(ex(8'h55, 1, 0, 1, 0)));
    nib(4'hD, 4'hD, 1'b1, 1'b1);
    chk("m_b_55_hold", 32'(ob()), 32'(ex(8'h55, 1, 0, 0, 0)));
    chk("m_a_55", 32'(oa()), 32'(ex(8'h55, 1, 0, 1, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("m_b_d5", 32'(ob()), 32'(ex(8'hD5, 1, 0, 1, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("m_b_end", 32'(ob()), 32'(ex(8'hD5, 1, 0, 0, 0)));

    // 100M: 7 nibbles, error on the third, odd tail
    nib(4'h1, 4'h1, 1'b1, 1'b1);
    nib(4'h2, 4'h2, 1'b1, 1'b1);
    nib(4'h3, 4'h3, 1'b1, 1'b0);
    chk("o_b_21", 32'(ob()), 32'(ex(8'h21, 1, 0, 1, 0)));
    nib(4'h4, 4'h4, 1'b1, 1'b1);
    chk("o_b_gap", 32'(ob()), 32'(ex(8'h21, 1, 0, 0, 0)));
    nib(4'h5, 4'h5, 1'b1, 1'b1);
    chk("o_b_43_er", 32'(ob()), 32'(ex(8'h43, 1, 1, 1, 0)));
    nib(4'h6, 4'h6, 1'b1, 1'b1);
    nib(4'h7, 4'h7, 1'b1, 1'b1);
    chk("o_b_65", 32'(ob()), 32'(ex(8'h65, 1, 0, 1, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("o_b_pend", 32'(ob()), 32'(ex(8'h65, 1, 0, 0, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("o_b_dribble", 32'(ob()), 32'(ex(8'h65, 1, 0, 0, 1)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("o_b_after", 32'(ob()), 32'(ex(8'h65, 1, 0, 0, 0)));
    chk("o_a_dribble", 32'(oa()), 32'(ex(8'h65, 1, 0, 0, 1)));

    // reset mid-frame with one nibble pending
    nib(4'h1, 4'h1, 1'b1, 1'b1);
    nib(4'h2, 4'h2, 1'b1, 1'b1);
    nib(4'h3, 4'h3, 1'b1, 1'b1);
    nib(4'h4, 4'h4, 1'b1, 1'b1);
    chk("r_a_21", 32'(oa()), 32'(ex(8'h21, 1, 0, 1, 0)));
    #1;
    rst = 1'b1;
    #1;
    chk("r_a_async", 32'(oa()), 32'h0);
    chk("r_b_async", 32'(ob()), 32'h0);
    chk("r_stat_async", 32'(sa()), 32'h0);
    nib(4'h4, 4'h4, 1'b1, 1'b1);
    nib(4'h5, 4'h5, 1'b1, 1'b1);
    rst = 1'b0;
    nib(4'h6, 4'h6, 1'b1, 1'b1);
    nib(4'h7, 4'h7, 1'b1, 1'b1);
    chk("r_b_quiet1", 32'(ob()), 32'h0);
    nib(4'h8, 4'h8, 1'b1, 1'b1);
    chk("r_b_quiet2", 32'(ob()), 32'h0);
    nib(4'h9, 4'h9, 1'b1, 1'b1);
    chk("r_b_quiet3", 32'(ob()), 32'h0);
    chk("r_a_quiet", 32'(oa()), 32'h0);
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    nib(4'hA, 4'hA, 1'b1, 1'b1);
    chk("r_stat_single", 32'(sa()), 32'h0);
    nib(4'hB, 4'hB, 1'b1, 1'b1);
    chk("r_b_pend", 32'(ob()), 32'h0);
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("r_b_ba", 32'(ob()), 32'(ex(8'hBA, 1, 0, 1, 0)));
    nib(4'hD, 4'hD, 1'b0, 1'b0);
    chk("r_a_ba", 32'(oa()), 32'(ex(8'hBA, 1, 0, 1, 0)));
    chk("r_b_ba_hold", 32'(ob()), 32'(ex(8'hBA, 1, 0, 0, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_adapter.md
RGMII_RX_ADAPTER -- requirements
Module: rgmii_rx_adapter

Interface
REQ-001 The block SHALL use one clock, RGMII_RxClk, sampled on both edges; reset rst SHALL be asynchronous and active-high.
REQ-002 Parameter PIPE_STAGES, default 1, range 0..4, sets the number of extra output register stages.
REQ-003 Parameter INBAND_STATUS, default 1; 1 enables in-band status decode, 0 holds the status outputs at 0.
REQ-004 Ports, listed as name, direction, width, meaning:
- RGMII_RxClk  in  1  RGMII receive clock.
- rst  in  1  async active-high reset.
- RGMII_RxD  in  4  DDR data.
- RGMII_RxCtl  in  1  DDR control: DV on the rising edge, DV^ER on the falling edge.
- Speed  in  2  00=10M, 01=100M, 10=1000M, 11 treated as 1000M.
- RxD  out  8  GMII byte.
- RxDV  out  1  data valid.
- RxER  out  1  receive error.
- RxValid  out  1  byte strobe / downstream clock enable.
- DribbleErr  out  1  one-cycle pulse when a frame ends on an odd nibble.
- LinkUp  out  1  in-band link status.
- LinkSpeed  out  2  in-band speed.
- FullDuplex  out  1  in-band duplex.
- StatusValid  out  1  high once status has been captured.

Function
REQ-005 Capture: on rising edge k, register low nibble L and DV; on the falling edge within cycle k, register high nibble H and C2; ER SHALL be DV^C2.
REQ-006 Re-time: at rising edge k+1, the pair {H,L}, DV and ER SHALL be aligned into the posedge domain.
REQ-007 Gigabit mode: byte = {H,L}; RxValid SHALL be 1 every cycle; outputs for edge k SHALL appear after rising edge k+1+PIPE_STAGES.
REQ-008 10/100 mode: only rising-edge samples are used; ER SHALL be DV^C2 of the same cycle.
REQ-009 10/100 mode: two consecutive nibbles, low first, SHALL form one byte; RxValid SHALL be 1 on alternate cycles only.
REQ-010 10/100 mode: the byte from nibbles at edges k and k+1 SHALL appear after edge k+2+PIPE_STAGES.
REQ-011 Nibble pairing phase SHALL reset on every DV 0->1 transition; the first nibble with DV=1 is the low nibble.
REQ-012 10/100 mode: if DV falls with one nibble pending, the nibble SHALL be discarded, no byte emitted, and DribbleErr SHALL pulse for 1 cycle aligned with where that byte would have appeared.
REQ-013 RxER in 10/100 mode SHALL be the OR of ER over both nibbles of the byte.
REQ-014 RxDV SHALL be the DV of the (last) nibble pair forming the byte; RxD, RxDV and RxER SHALL hold their values on cycles where RxValid=0.
REQ-015 DV=0 with ER=1 (false carrier / carrier extend) SHALL pass through as RxDV=0, RxER=1, with RxD carrying the captured data.
REQ-016 Speed SHALL be sampled only while the aligned DV=0; a change during a frame SHALL take effect after DV falls.
REQ-017 Speed change SHALL clear the nibble-pair state; no partial byte SHALL be emitted.
REQ-018 In-band status: when INBAND_STATUS=1 and the aligned DV=0 and ER=0, decode L as bit0=LinkUp, bits[2:1]=LinkSpeed, bit3=FullDuplex.
REQ-019 Status registers SHALL update only when the same status nibble is seen on 2 consecutive qualifying cycles; StatusValid SHALL be set on the first update and stay set until reset.
REQ-020 Status decode SHALL ignore cycles with DV=1 or ER=1.
REQ-021 Every pipeline stage SHALL register RxD, RxDV, RxER, RxValid and DribbleErr together.

Reset
REQ-022 On rst=1, all outputs SHALL go to 0 immediately, as SHALL all capture, pipeline and status registers and the nibble phase.
REQ-023 After rst deasserts, the first valid output SHALL require a full DV 0->1 transition; a frame in progress at reset release SHALL be output with RxDV only from data captured after release, never from pre-reset state.
REQ-024 In 10/100 mode, pairing SHALL wait for a DV rising edge after reset release.

Verification
REQ-025 Gigabit, PIPE_STAGES=1: drive L=5,H=5 on edge k, then D5 (L=5,H=D), DV=1, ER=0 -> RxD=0x55 after edge k+2, then 0xD5; RxValid=1 every cycle.
REQ-026 100M, PIPE_STAGES=0: nibbles 5,5,5,D with DV=1 -> RxD=0x55 then 0xD5, RxValid alternating, bytes at edges k+2 and k+4.
REQ-027 100M: frame of 7 nibbles -> 3 bytes emitted, DribbleErr pulses once, no 4th RxValid.
REQ-028 Ctl rising=1, falling=0 in gigabit mode -> RxDV=1, RxER=1; ctl rising=0, falling=1, data 0xF -> RxDV=0, RxER=1, RxD=0xFF.
REQ-029 Idle nibble 0xD (DV=0, ER=0) for 2 cycles -> LinkUp=1, LinkSpeed=10, FullDuplex=1, StatusValid=1; a single-cycle 0x0 glitch -> no change.
REQ-030 Assert rst mid-frame in 10/100 with one nibble pending -> all outputs 0 asynchronously; after release, no byte until the next DV rise.
